// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : PC owner; one-outstanding imem fetch into a small FIFO.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_REQ_ADDR,
    input  logic        IMEM_RESP_VALID,
    input  logic [31:0] IMEM_RESP_DATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] INST_PC
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_CR = DEPTH[c_CNT_W:0];

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          w_fetch_pc_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;
    logic [31:0]          r_tag;
    logic [31:0]          w_tag_nxt;

    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [31:0]          r_fifo_pc   [DEPTH];
    logic [31:0]          r_fifo_inst [DEPTH];

    logic [c_CNT_W:0]     w_credit;
    logic                 w_req_fire;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused;

    assign w_unused       = ^REDIRECT_PC[1:0];

    // Credit counts the FIFO slot reserved by the in-flight request.
    assign w_credit       = {1'b0, r_count} + {{c_CNT_W{1'b0}}, (r_state == S_WAIT)};
    assign IMEM_REQ_VALID = (r_state == S_REQ) && (w_credit < c_DEPTH_CR) && !RST;
    assign IMEM_REQ_ADDR  = r_fetch_pc;
    assign w_req_fire     = IMEM_REQ_VALID && IMEM_REQ_READY;

    assign INST_VALID     = (r_count != '0);
    assign INSTRUCTION    = r_fifo_inst[r_rd_ptr];
    assign INST_PC        = r_fifo_pc[r_rd_ptr];

    assign w_push = (r_state == S_WAIT) && IMEM_RESP_VALID && !r_drop && !REDIRECT;
    assign w_pop  = INST_VALID && INST_READY && !REDIRECT;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        w_tag_nxt      = r_tag;
        if (REDIRECT) begin
            w_fetch_pc_nxt = {REDIRECT_PC[31:2], 2'b00};
            // A request still in flight after this edge must have its word discarded.
            if (w_req_fire || ((r_state == S_WAIT) && !IMEM_RESP_VALID)) begin
                w_state_nxt = S_WAIT;
                w_drop_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_REQ;
                w_drop_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        w_state_nxt    = S_WAIT;
                        w_tag_nxt      = r_fetch_pc;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (IMEM_RESP_VALID) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_tag      <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_tag      <= w_tag_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= 32'd0;
                r_fifo_inst[i] <= 32'd0;
            end
        end else if (REDIRECT) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_tag;
                r_fifo_inst[r_wr_ptr] <= IMEM_RESP_DATA;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter. It requests 32-bit instruction words from instruction memory over a valid/ready request channel and buffers the returned words in a small FIFO. Buffered instructions are presented, with their PC, to the decode stage over a valid/ready handshake. A redirect input from execute flushes all fetched state and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IMEM_REQ_VALID  out  1  fetch request valid
- IMEM_REQ_READY  in  1  memory accepts request
- IMEM_REQ_ADDR  out  32  byte address of requested word
- IMEM_RESP_VALID  in  1  response word valid (always accepted; no backpressure)
- IMEM_RESP_DATA  in  32  instruction word
- REDIRECT  in  1  flush and restart fetch
- REDIRECT_PC  in  32  new fetch address; bits [1:0] ignored, forced to 0
- INST_VALID  out  1  FIFO head valid
- INST_READY  in  1  decode consumes head
- INSTRUCTION  out  32  FIFO head instruction
- INST_PC  out  32  PC of FIFO head

## Operation
- Registers: fetch_pc, state {S_REQ, S_WAIT}, drop flag, FIFO of {pc, inst} with count.
- At most one outstanding memory request. credit = count + (state==S_WAIT).
- IMEM_REQ_VALID = (state==S_REQ) && credit < DEPTH && !RST. IMEM_REQ_ADDR = fetch_pc.
- S_REQ: on IMEM_REQ_VALID && IMEM_REQ_READY → S_WAIT, record fetch_pc as the tag, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC → 0).
- S_WAIT: on IMEM_RESP_VALID → S_REQ. If drop==0, push {tag, IMEM_RESP_DATA}. If drop==1, discard the word and clear drop.
- IMEM_RESP_VALID in S_REQ is ignored; it is a protocol error and must not push.
- Pop when INST_VALID && INST_READY. Push and pop in the same cycle leave count unchanged. Overflow cannot occur because of the credit rule.
- REDIRECT has priority over every other event in its cycle:
  - FIFO count <= 0, so no pop takes effect and no push occurs.
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - If a request is outstanding after this edge (state==S_WAIT without a response this cycle, or a handshake completes this cycle), go to or stay in S_WAIT with drop <= 1.
  - A response arriving in the redirect cycle is discarded, and the next state is S_REQ.
  - Otherwise the next state is S_REQ.
- Consecutive REDIRECT cycles: the last one wins. drop stays set while a request is outstanding.
- RST: fetch_pc <= RESET_PC, state <= S_REQ, drop <= 0, count <= 0, FIFO pointers <= 0. An in-flight response arriving after reset deasserts is ignored, because state is S_REQ.

## Timing
- Reset values (cycle after RST high): IMEM_REQ_VALID 0, IMEM_REQ_ADDR RESET_PC, INST_VALID 0, INSTRUCTION 0, INST_PC 0.
- First request: IMEM_REQ_VALID is high in the first cycle with RST low.
- IMEM_REQ_VALID and IMEM_REQ_ADDR are held stable until IMEM_REQ_READY, unless REDIRECT or RST occurs.
- Response latency from memory is ≥1 cycle after the accepting edge and is otherwise arbitrary.
- A word pushed at edge t has INST_VALID high in cycle t+1, meaning decode sees it one cycle after the response.
- With single-cycle memory and no stalls, steady-state throughput is one instruction per 2 cycles. Request-to-INST_VALID latency is 2 cycles.
- After REDIRECT at edge t: INST_VALID is 0 in cycle t+1. A new request at REDIRECT_PC is raised in cycle t+1 if nothing is outstanding, otherwise in the cycle after the dropped response.
- INSTRUCTION and INST_PC are registered FIFO-head outputs. Their values are don't-care while INST_VALID is 0, except after reset.

## Test plan
- Reset, RESET_PC=0x100, memory ready, 1-cycle response, INST_READY=1: requests at 0x100, 0x104, 0x108. Decode receives (0x100,w0), (0x104,w1), (0x108,w2), each with INST_VALID one cycle after its response.
- INST_READY=0, DEPTH=2: exactly 2 requests issue, then IMEM_REQ_VALID stays 0. Raising INST_READY pops 0x100 and a request for 0x108 follows.
- IMEM_REQ_READY held low for 5 cycles: IMEM_REQ_VALID stays high and IMEM_REQ_ADDR stays at 0x104 throughout, and fetch_pc does not advance.
- Request 0x104 outstanding with 3-cycle latency, REDIRECT to 0x203 in the wait: FIFO empties and the 0x104 response is dropped. The next request is 0x200, and decode receives only (0x200, …).
- REDIRECT in the same cycle as a response and a pop: nothing pushes, count is 0, and the next cycle requests REDIRECT_PC.
- RST asserted mid-wait with 2 FIFO entries: INST_VALID is 0 next cycle, the late response is ignored, and fetch restarts at RESET_PC. PC wrap check: RESET_PC=0xFFFF_FFFC is followed by a request at 0x0.
